// File: rtl/block_sequencer.sv
// Block ROM walker: fetches block descriptors for the selected song and emits one note address per tempo tick.
// Optional BLOCK_SEQ_LOOP_EN: replay the song endlessly until stop, pulsing done once per pass.
module block_sequencer #(
   parameter int ROM_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        stop,
   input  logic [1:0]  song_sel,
   input  logic        step,
   output logic [8:0]  rom_addr,
   input  logic [14:0] rom_dout,
   output logic [8:0]  note_addr,
   output logic        note_valid,
   output logic        block_first,
   output logic [2:0]  prev_size,
   output logic        busy,
   output logic        done,
   output logic        overrun
);

   typedef enum logic [2:0] {IDLE, FETCH, WAIT, PLAY, DONE} state_t;

   state_t     state_reg, state_next;
   logic [1:0] song_reg, song_next;
   logic [8:0] rom_addr_reg, rom_addr_next;
   logic [4:0] blk_cnt_reg, blk_cnt_next;
   logic [8:0] start_addr_reg, start_addr_next;
   logic [2:0] cur_size_reg, cur_size_next;
   logic [2:0] prev_size_reg, prev_size_next;
   logic [2:0] offset_reg, offset_next;
   logic [8:0] note_addr_reg, note_addr_next;
   logic       note_valid_reg, note_valid_next;
   logic       block_first_reg, block_first_next;
   logic       done_reg, done_next;
   logic       overrun_reg, overrun_next;
   logic       pend_reg, pend_next;
   logic       last_blk, tick, end_of_song;

   generate
      if (ROM_LAT != 1) begin : g_bad_rom_lat
         $error("block_sequencer supports ROM_LAT == 1 only");
      end
   endgenerate

   function automatic logic [8:0] song_base(input logic [1:0] s);
      case (s)
         2'd0:    return 9'd0;
         2'd1:    return 9'd16;
         2'd2:    return 9'd48;
         default: return 9'd64;
      endcase
   endfunction

   // Index of the final block in each song (block count - 1).
   function automatic logic [4:0] song_last(input logic [1:0] s);
      case (s)
         2'd0:    return 5'd15;
         2'd1:    return 5'd31;
         2'd2:    return 5'd15;
         default: return 5'd31;
      endcase
   endfunction

   assign last_blk = (blk_cnt_reg == song_last(song_reg));
   assign tick     = pend_reg | step;

   always_comb begin
      state_next       = state_reg;
      song_next        = song_reg;
      rom_addr_next    = rom_addr_reg;
      blk_cnt_next     = blk_cnt_reg;
      start_addr_next  = start_addr_reg;
      cur_size_next    = cur_size_reg;
      prev_size_next   = prev_size_reg;
      offset_next      = offset_reg;
      note_addr_next   = note_addr_reg;
      note_valid_next  = 1'b0;
      block_first_next = 1'b0;
      done_next        = 1'b0;
      overrun_next     = overrun_reg;
      pend_next        = pend_reg;
      end_of_song      = 1'b0;

      if (stop && state_reg != IDLE) begin
         state_next = IDLE;
         pend_next  = 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start && !stop) begin
                  song_next     = song_sel;
                  rom_addr_next = song_base(song_sel);
                  blk_cnt_next  = 5'd0;
                  overrun_next  = 1'b0;
                  pend_next     = 1'b0;
                  state_next    = FETCH;
               end
            end
            FETCH, WAIT: begin
               // Notes cannot issue here, so buffer one tick and flag any further one.
               if (step) begin
                  if (pend_reg) overrun_next = 1'b1;
                  else          pend_next    = 1'b1;
               end
               if (state_reg == FETCH) begin
                  state_next = WAIT;
               end else begin
                  start_addr_next = rom_dout[14:6];
                  prev_size_next  = rom_dout[5:3];
                  cur_size_next   = rom_dout[2:0];
                  offset_next     = 3'd0;
                  if (rom_dout[2:0] != 3'd0) begin
                     state_next = PLAY;
                  end else if (last_blk) begin
                     end_of_song = 1'b1;
                  end else begin
                     rom_addr_next = rom_addr_reg + 9'd1;
                     blk_cnt_next  = blk_cnt_reg + 5'd1;
                     state_next    = FETCH;
                  end
               end
            end
            PLAY: begin
               // A buffered tick wins; a step arriving alongside it is dropped.
               if (pend_reg) begin
                  pend_next = 1'b0;
                  if (step) overrun_next = 1'b1;
               end
               if (tick) begin
                  note_addr_next   = start_addr_reg + {6'd0, offset_reg};
                  note_valid_next  = 1'b1;
                  block_first_next = (offset_reg == 3'd0);
                  if (offset_reg == cur_size_reg - 3'd1) begin
                     if (last_blk) begin
                        end_of_song = 1'b1;
                     end else begin
                        rom_addr_next = rom_addr_reg + 9'd1;
                        blk_cnt_next  = blk_cnt_reg + 5'd1;
                        state_next    = FETCH;
                     end
                  end else begin
                     offset_next = offset_reg + 3'd1;
                  end
               end
            end
            DONE: begin
               done_next  = 1'b1;
               state_next = IDLE;
            end
            default: state_next = IDLE;
         endcase

         if (end_of_song) begin
`ifdef BLOCK_SEQ_LOOP_EN
            rom_addr_next = song_base(song_reg);
            blk_cnt_next  = 5'd0;
            done_next     = 1'b1;
            state_next    = FETCH;
`else
            state_next = DONE;
`endif
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= IDLE;
         song_reg        <= 2'd0;
         rom_addr_reg    <= 9'd0;
         blk_cnt_reg     <= 5'd0;
         start_addr_reg  <= 9'd0;
         cur_size_reg    <= 3'd0;
         prev_size_reg   <= 3'd0;
         offset_reg      <= 3'd0;
         note_addr_reg   <= 9'd0;
         note_valid_reg  <= 1'b0;
         block_first_reg <= 1'b0;
         done_reg        <= 1'b0;
         overrun_reg     <= 1'b0;
         pend_reg        <= 1'b0;
      end else begin
         state_reg       <= state_next;
         song_reg        <= song_next;
         rom_addr_reg    <= rom_addr_next;
         blk_cnt_reg     <= blk_cnt_next;
         start_addr_reg  <= start_addr_next;
         cur_size_reg    <= cur_size_next;
         prev_size_reg   <= prev_size_next;
         offset_reg      <= offset_next;
         note_addr_reg   <= note_addr_next;
         note_valid_reg  <= note_valid_next;
         block_first_reg <= block_first_next;
         done_reg        <= done_next;
         overrun_reg     <= overrun_next;
         pend_reg        <= pend_next;
      end
   end

   assign rom_addr    = rom_addr_reg;
   assign note_addr   = note_addr_reg;
   assign note_valid  = note_valid_reg;
   assign block_first = block_first_reg;
   assign prev_size   = prev_size_reg;
   assign busy        = (state_reg != IDLE);
   assign done        = done_reg;
   assign overrun     = overrun_reg;

endmodule

// File: tb/tb_block_sequencer.sv
// Directed bench for block_sequencer: a registered-read block ROM model plus a note/done monitor.
// Song 3 contains empty blocks (k=1 and the final k=31) to exercise the zero-size path.
module tb_block_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [1:0]  song_sel = 2'd0;
   logic        step = 1'b0;
   logic [8:0]  rom_addr;
   logic [14:0] rom_dout = 15'd0;
   logic [8:0]  note_addr;
   logic        note_valid;
   logic        block_first;
   logic [2:0]  prev_size;
   logic        busy;
   logic        done;
   logic        overrun;

   logic [14:0] rom [0:511];
   logic [8:0]  q_addr [$];
   bit          q_first [$];
   logic [2:0]  q_prev [$];
   bit          q_ovr [$];
   int cyc = 0;
   int last_note_cyc, done_cyc, done_cnt;
   bit done_busy;
   int n_total = 0;
   int n_pass = 0;

   block_sequencer #(.ROM_LAT(1)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .song_sel(song_sel),
      .step(step), .rom_addr(rom_addr), .rom_dout(rom_dout), .note_addr(note_addr),
      .note_valid(note_valid), .block_first(block_first), .prev_size(prev_size),
      .busy(busy), .done(done), .overrun(overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      rom_dout <= rom[rom_addr];
      cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (note_valid) begin
            q_addr.push_back(note_addr);
            q_first.push_back(block_first);
            q_prev.push_back(prev_size);
            q_ovr.push_back(overrun);
            last_note_cyc = cyc;
         end
         if (done) begin
            done_cnt++;
            done_cyc  = cyc;
            done_busy = busy;
         end
      end
   end

   // Descriptor = {start[8:0], prev[2:0], size[2:0]}
   initial begin
      for (int b = 0; b < 512; b++) rom[b] = 15'd0;
      for (int k = 0; k < 16; k++) rom[k]      = {9'(4 * k), (k == 0) ? 3'd0 : 3'd4, 3'd4};
      for (int k = 0; k < 32; k++) rom[16 + k] = {9'(128 + 2 * k), (k == 0) ? 3'd0 : 3'd2, 3'd2};
      for (int k = 0; k < 16; k++) rom[48 + k] = {9'(256 + 2 * k), (k == 0) ? 3'd0 : 3'd2, 3'd2};
      for (int k = 0; k < 32; k++) rom[64 + k] = {9'(320 + k), (k == 0) ? 3'd0 : 3'd1,
                                                  (k == 1 || k == 31) ? 3'd0 : 3'd1};
   end

   task automatic clear_mon();
      q_addr.delete(); q_first.delete(); q_prev.delete(); q_ovr.delete();
      done_cnt = 0; last_note_cyc = -1; done_cyc = -1; done_busy = 1'b1;
   endtask

   task automatic do_start(input logic [1:0] sel);
      @(negedge clk); start = 1'b1; song_sel = sel;
      @(negedge clk); start = 1'b0;
   endtask

   // Pulse step every `period` cycles until done; optional stray start pulses at cycles inj1/inj2.
   task automatic run_steps(input int period, input int max_c, input int inj1, input int inj2);
      int c = 0;
      while (done_cnt == 0 && c < max_c) begin
         c++;
         step = (c % period == 0);
         if (c == inj1 || c == inj2) begin start = 1'b1; song_sel = 2'd3; end
         else start = 1'b0;
         @(negedge clk);
      end
      step = 1'b0; start = 1'b0;
      n_total++; if (done_cnt == 0) $display("FAIL run_timeout: got no done after %0d cycles, want done", c); else n_pass++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_total++; if (rom_addr !== 9'd0) $display("FAIL reset_rom_addr: got %0d want 0", rom_addr); else n_pass++;
      n_total++; if (note_addr !== 9'd0) $display("FAIL reset_note_addr: got %0d want 0", note_addr); else n_pass++;
      n_total++; if (prev_size !== 3'd0) $display("FAIL reset_prev_size: got %0d want 0", prev_size); else n_pass++;
      n_total++; if ({note_valid, block_first, busy, done, overrun} !== 5'b0)
         $display("FAIL reset_flags: got %b want 00000", {note_valid, block_first, busy, done, overrun}); else n_pass++;
      rst = 1'b0;
      @(negedge clk);
      n_total++; if (busy !== 1'b0) $display("FAIL idle_busy: got %0b want 0", busy); else n_pass++;
   endtask

   task automatic test_song0();
      clear_mon();
      do_start(2'd0);
      n_total++; if (busy !== 1'b1) $display("FAIL s0_busy_after_start: got %0b want 1", busy); else n_pass++;
      n_total++; if (rom_addr !== 9'd0) $display("FAIL s0_rom_addr: got %0d want 0", rom_addr); else n_pass++;
      run_steps(8, 3000, 0, 0);
      n_total++; if (q_addr.size() != 64) $display("FAIL s0_note_count: got %0d want 64", q_addr.size()); else n_pass++;
      for (int i = 0; i < 64 && i < q_addr.size(); i++) begin
         n_total++; if (q_addr[i] !== 9'(i)) $display("FAIL s0_addr[%0d]: got %0d want %0d", i, q_addr[i], i); else n_pass++;
         n_total++; if (q_first[i] !== (i % 4 == 0)) $display("FAIL s0_first[%0d]: got %0b want %0b", i, q_first[i], (i % 4 == 0)); else n_pass++;
      end
      @(negedge clk);
      n_total++; if (done_cnt != 1) $display("FAIL s0_done_count: got %0d want 1", done_cnt); else n_pass++;
      n_total++; if (done_cyc != last_note_cyc + 1) $display("FAIL s0_done_timing: got cycle %0d want %0d", done_cyc, last_note_cyc + 1); else n_pass++;
      n_total++; if (done_busy !== 1'b0) $display("FAIL s0_busy_at_done: got %0b want 0", done_busy); else n_pass++;
      n_total++; if (overrun !== 1'b0) $display("FAIL s0_overrun: got %0b want 0", overrun); else n_pass++;
   endtask

   task automatic test_song1();
      clear_mon();
      do_start(2'd1);
      run_steps(4, 3000, 0, 0);
      n_total++; if (q_addr.size() != 64) $display("FAIL s1_note_count: got %0d want 64", q_addr.size()); else n_pass++;
      for (int i = 0; i < 64 && i < q_addr.size(); i++) begin
         n_total++; if (q_addr[i] !== 9'(128 + i)) $display("FAIL s1_addr[%0d]: got %0d want %0d", i, q_addr[i], 128 + i); else n_pass++;
         n_total++; if (q_prev[i] !== ((i < 2) ? 3'd0 : 3'd2)) $display("FAIL s1_prev[%0d]: got %0d want %0d", i, q_prev[i], (i < 2) ? 0 : 2); else n_pass++;
      end
      n_total++; if (q_addr.size() == 0 || q_addr[q_addr.size() - 1] !== 9'd191)
         $display("FAIL s1_last_note: got %0d want 191", (q_addr.size() == 0) ? 0 : q_addr[q_addr.size() - 1]); else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_overrun();
      clear_mon();
      do_start(2'd2);
      repeat (2) @(negedge clk);
      run_steps(1, 500, 0, 0);
      n_total++; if (q_addr.size() != 32) $display("FAIL s2_note_count: got %0d want 32", q_addr.size()); else n_pass++;
      for (int i = 0; i < 32 && i < q_addr.size(); i++) begin
         n_total++; if (q_addr[i] !== 9'(256 + i)) $display("FAIL s2_addr[%0d]: got %0d want %0d", i, q_addr[i], 256 + i); else n_pass++;
      end
      n_total++; if (q_ovr.size() < 3 || q_ovr[1] !== 1'b0 || q_ovr[2] !== 1'b1)
         $display("FAIL s2_overrun_onset: got %0d notes / %b,%b want 0 then 1", q_ovr.size(),
                  (q_ovr.size() > 1) ? q_ovr[1] : 1'b0, (q_ovr.size() > 2) ? q_ovr[2] : 1'b0); else n_pass++;
      @(negedge clk);
      n_total++; if (overrun !== 1'b1) $display("FAIL s2_overrun_sticky: got %0b want 1", overrun); else n_pass++;
   endtask

   task automatic test_stop();
      int c = 0;
      clear_mon();
      do_start(2'd3);
      step = 1'b1;
      while (rom_addr !== 9'd67 && c < 500) begin @(negedge clk); c++; end
      n_total++; if (rom_addr !== 9'd67) $display("FAIL stop_reach_blk3: got %0d want 67", rom_addr); else n_pass++;
      @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0; step = 1'b0;
      n_total++; if (busy !== 1'b0) $display("FAIL stop_busy: got %0b want 0", busy); else n_pass++;
      n_total++; if (note_valid !== 1'b0) $display("FAIL stop_note_valid: got %0b want 0", note_valid); else n_pass++;
      n_total++; if (q_addr.size() != 2) $display("FAIL stop_notes: got %0d want 2", q_addr.size()); else n_pass++;
      n_total++; if (overrun !== 1'b1) $display("FAIL stop_overrun_kept: got %0b want 1", overrun); else n_pass++;
      repeat (3) @(negedge clk);
      n_total++; if (done_cnt != 0) $display("FAIL stop_no_done: got %0d want 0", done_cnt); else n_pass++;
      do_start(2'd0);
      n_total++; if (overrun !== 1'b0) $display("FAIL restart_overrun: got %0b want 0", overrun); else n_pass++;
      repeat (2) @(negedge clk);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      n_total++; if (note_valid !== 1'b1) $display("FAIL restart_valid: got %0b want 1", note_valid); else n_pass++;
      n_total++; if (note_addr !== 9'd0) $display("FAIL restart_addr: got %0d want 0", note_addr); else n_pass++;
      n_total++; if (block_first !== 1'b1) $display("FAIL restart_first: got %0b want 1", block_first); else n_pass++;
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      n_total++; if (busy !== 1'b0) $display("FAIL restart_stop_busy: got %0b want 0", busy); else n_pass++;
   endtask

   task automatic test_start_busy();
      clear_mon();
      do_start(2'd0);
      run_steps(3, 3000, 20, 101);
      n_total++; if (q_addr.size() != 64) $display("FAIL sb_note_count: got %0d want 64", q_addr.size()); else n_pass++;
      for (int i = 0; i < 64 && i < q_addr.size(); i++) begin
         n_total++; if (q_addr[i] !== 9'(i)) $display("FAIL sb_addr[%0d]: got %0d want %0d", i, q_addr[i], i); else n_pass++;
      end
      @(negedge clk);
      n_total++; if (done_cnt != 1) $display("FAIL sb_done_count: got %0d want 1", done_cnt); else n_pass++;
   endtask

   task automatic test_empty_blocks();
      logic [8:0] exp_q [$];
      for (int k = 0; k < 32; k++) if (k != 1 && k != 31) exp_q.push_back(9'(320 + k));
      clear_mon();
      do_start(2'd3);
      run_steps(3, 3000, 0, 0);
      n_total++; if (q_addr.size() != exp_q.size()) $display("FAIL s3_note_count: got %0d want %0d", q_addr.size(), exp_q.size()); else n_pass++;
      for (int i = 0; i < exp_q.size() && i < q_addr.size(); i++) begin
         n_total++; if (q_addr[i] !== exp_q[i]) $display("FAIL s3_addr[%0d]: got %0d want %0d", i, q_addr[i], exp_q[i]); else n_pass++;
      end
      @(negedge clk);
      n_total++; if (done_cnt != 1) $display("FAIL s3_done_count: got %0d want 1", done_cnt); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL s3_busy_end: got %0b want 0", busy); else n_pass++;
   endtask

   task automatic test_reset_mid_play();
      clear_mon();
      do_start(2'd1);
      repeat (2) @(negedge clk);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      n_total++; if (note_valid !== 1'b1 || note_addr !== 9'd128)
         $display("FAIL rmp_note: got valid %0b addr %0d want 1 / 128", note_valid, note_addr); else n_pass++;
      rst = 1'b1;
      #1;
      n_total++; if (rom_addr !== 9'd0) $display("FAIL rmp_rom_addr: got %0d want 0", rom_addr); else n_pass++;
      n_total++; if (note_addr !== 9'd0) $display("FAIL rmp_note_addr: got %0d want 0", note_addr); else n_pass++;
      n_total++; if (prev_size !== 3'd0) $display("FAIL rmp_prev_size: got %0d want 0", prev_size); else n_pass++;
      n_total++; if ({note_valid, block_first, busy, done, overrun} !== 5'b0)
         $display("FAIL rmp_flags: got %b want 00000", {note_valid, block_first, busy, done, overrun}); else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

`ifdef BLOCK_SEQ_LOOP_EN
   task automatic test_loop();
      int c = 0;
      clear_mon();
      do_start(2'd2);
      while (q_addr.size() < 40 && c < 2000) begin
         c++;
         step = (c % 4 == 0);
         @(negedge clk);
      end
      step = 1'b0;
      n_total++; if (q_addr.size() < 40) $display("FAIL loop_note_count: got %0d want 40", q_addr.size()); else n_pass++;
      for (int i = 0; i < 40 && i < q_addr.size(); i++) begin
         n_total++; if (q_addr[i] !== 9'(256 + i % 32)) $display("FAIL loop_addr[%0d]: got %0d want %0d", i, q_addr[i], 256 + i % 32); else n_pass++;
      end
      n_total++; if (done_cnt != 1) $display("FAIL loop_done_count: got %0d want 1", done_cnt); else n_pass++;
      n_total++; if (done_busy !== 1'b1 || busy !== 1'b1) $display("FAIL loop_busy: got %0b/%0b want 1/1", done_busy, busy); else n_pass++;
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      n_total++; if (busy !== 1'b0) $display("FAIL loop_stop_busy: got %0b want 0", busy); else n_pass++;
   endtask
`endif

   initial begin
      test_reset();
      test_song0();
      test_song1();
      test_overrun();
      test_stop();
      test_start_busy();
      test_empty_blocks();
      test_reset_mid_play();
`ifdef BLOCK_SEQ_LOOP_EN
      test_loop();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/block_sequencer.md
# block_sequencer

Reader for the block ROM in the note-display path. On `start` it walks every block of the selected song in order, fetches each block descriptor (start address, previous and current block size), and emits one note address per `step` tick for use by the downstream note ROM and display logic. It sits between the tempo tick generator and the note ROM, and it owns the block ROM's address port.

## Interface
Parameters:
- `ROM_LAT`, 1 – block ROM read latency in cycles. This block supports the value 1 only.

Ports:
- `clk`  in  1  – system clock.
- `rst`  in  1  – asynchronous, active-high reset.
- `start`  in  1  – one-cycle request to begin a song. Ignored while `busy`.
- `stop`  in  1  – abort the current song and return to idle.
- `song_sel`  in  2  – song index. Sampled only on an accepted `start`.
- `step`  in  1  – tempo tick. Each tick advances one note.
- `rom_addr`  out  9  – block index, registered, driven to the block ROM.
- `rom_dout`  in  15  – ROM data: [14:6] start address, [5:3] previous size, [2:0] current size.
- `note_addr`  out  9  – address of the current note.
- `note_valid`  out  1  – one-cycle pulse when `note_addr` is updated.
- `block_first`  out  1  – qualifies `note_valid`. High on the first note of a block.
- `prev_size`  out  3  – previous block size of the current block, latched from the ROM.
- `busy`  out  1  – high in every state except IDLE.
- `done`  out  1  – one-cycle pulse after the last note of a song.
- `overrun`  out  1  – sticky flag. Set when a tick is lost. Cleared by `rst` or an accepted `start`.

## Operation
- Song table (fixed): base block {0, 16, 48, 64} and block count {16, 32, 16, 32} for songs 0 to 3.
- States: IDLE, FETCH, WAIT, PLAY, DONE.
- IDLE, on `start`:
  - Latch the song.
  - Set `rom_addr` to the song's base block and set the block counter to 0.
  - Clear `overrun` and the pending tick.
  - Go to FETCH.
- FETCH: the ROM samples `rom_addr`. Go to WAIT unconditionally.
- WAIT:
  - `rom_dout` is valid. Latch start address, `prev_size` and current size, and clear the note offset.
  - If current size = 0, the block is empty. If it is the last block, go to DONE. Otherwise increment `rom_addr` and the block counter and go to FETCH.
  - If current size ≠ 0, go to PLAY.
- PLAY, on `step` or a pending tick:
  - Set `note_addr` to start address + offset (9-bit, wraps mod 512) and pulse `note_valid`.
  - Assert `block_first` when offset = 0.
  - If offset = size−1 and this is the last block, go to DONE.
  - If offset = size−1 and it is not the last block, increment `rom_addr` and the block counter and go to FETCH.
  - Otherwise increment the offset.
- DONE: pulse `done` for one cycle, then go to IDLE.
- Pending tick:
  - A `step` in FETCH or WAIT sets a one-deep pending flag.
  - A pending tick is consumed on the first PLAY cycle, ahead of any `step` in that same cycle.
  - A `step` that arrives while the flag is already set, or a `step` coincident with pending consumption in PLAY, sets `overrun`. The extra tick is dropped.
- `stop` takes priority over everything, in any non-IDLE state:
  - Next state is IDLE and the pending flag is cleared.
  - No `done` pulse and no `note_valid` are produced in that cycle.
- `start` and `stop` in the same cycle while in IDLE: `stop` wins and the block stays in IDLE.

## Timing
- Reset values:
  - `rom_addr` = 0, `note_addr` = 0, `prev_size` = 0.
  - `note_valid`, `block_first`, `busy`, `done`, `overrun` all 0.
  - State = IDLE and the pending flag is clear.
- `start` accepted at edge N: `busy` = 1 after N. FETCH during cycle N+1, WAIT during N+2, PLAY from N+3.
- Block change costs 2 cycles (FETCH, WAIT). No note can issue in those cycles, which is why up to one tick is buffered.
- `note_valid`, `note_addr` and `block_first` are registered and appear the cycle after the `step` edge, or the cycle after PLAY entry for a pending tick.
- `done` is asserted the cycle after the final `note_valid`. `busy` falls together with `done`.

## Configuration
- `BLOCK_SEQ_LOOP_EN`
  - Defined: after the last note of the last block, the sequencer reloads the song's base block and goes to FETCH instead of DONE. `done` pulses once per completed pass, coincident with that FETCH cycle. Only `stop` ends playback.
  - Undefined: single pass, terminating in DONE → IDLE as described above.

## Test plan
- Song 0, `start`, `step` every 8 cycles: `note_addr` = 0, 1, …, 63. `block_first` is high at 0, 4, 8, …, 60. `done` pulses once after 63 and `busy` then falls.
- Song 1: 64 notes, addresses 128 to 191. `prev_size` = 0 on block 16 and 2 on every later block. The last `note_valid` carries 191.
- `step` on every cycle for song 2: one tick is buffered across each fetch and `overrun` sets at the first block boundary. Verify no lost-note duplication.
- `stop` in WAIT during block 3 of song 3: IDLE next cycle, no `done`. A fresh `start` with `song_sel` = 0 gives first `note_addr` = 0 with `overrun` cleared.
- `start` pulsed while `busy`: ignored, and the song sequence is unchanged. `rst` mid-PLAY forces all outputs to their reset values immediately.
- With `BLOCK_SEQ_LOOP_EN` on song 2: after 286, 287 the next note is 256. `done` pulses at the wrap and `busy` stays high.
